// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl
//   Sequences register-transfer requests onto the shared datapath bus. Each
//   request names a 5-bit source and destination code. A legal transfer drives
//   its source for two cycles (DRIVE, LATCH) and strobes its destination load in
//   the second cycle. A one-entry skid buffer holds the next transfer while the
//   current one runs.
//
// Ports
//   i_clock      single clock, rising edge
//   i_clear      asynchronous active-high reset
//   i_req_valid  transfer request present
//   i_req_src    source code (0..NSRC-1 legal)
//   i_req_dst    destination code (0..NDST-1 legal)
//   o_req_ready  request accepted when i_req_valid && o_req_ready
//   o_src_out    one-hot source drive enables
//   o_dst_in     one-hot destination load strobes
//   o_done       one-cycle pulse after a transfer's LATCH cycle
//   o_err        one-cycle pulse after an illegal request is accepted
//   o_busy       FSM active or buffer occupied
module bus_xfer_ctrl #(
  parameter int unsigned NSRC = 24,
  parameter int unsigned NDST = 25
) (
  input  logic            i_clock,
  input  logic            i_clear,
  input  logic            i_req_valid,
  input  logic [4:0]      i_req_src,
  input  logic [4:0]      i_req_dst,
  output logic            o_req_ready,
  output logic [NSRC-1:0] o_src_out,
  output logic [NDST-1:0] o_dst_in,
  output logic            o_done,
  output logic            o_err,
  output logic            o_busy
);

  typedef enum logic [1:0] {StIdle, StDrive, StLatch} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [4:0] r_cur_src;
  logic [4:0] r_cur_dst;
  logic [4:0] r_buf_src;
  logic [4:0] r_buf_dst;
  logic       r_buf_valid;
  logic       r_done;
  logic       r_err;

  logic       w_accept;
  logic       w_req_legal;
  logic       w_pop;
  logic       w_push;
  logic       w_start_new;

  // Ready depends only on buffer occupancy, never on the request itself.
  assign o_req_ready = !r_buf_valid;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_req_legal = (32'(i_req_src) < NSRC) && (32'(i_req_dst) < NDST);

  // The buffer issues whenever the FSM is free to start (IDLE or leaving LATCH),
  // so a buffered request always wins over the input port.
  assign w_pop       = r_buf_valid && (r_state != StDrive);
  // Idle with an empty buffer: a legal request bypasses the buffer.
  assign w_start_new = (r_state == StIdle) && w_accept && w_req_legal;
  // Illegal requests complete the handshake but never enter the buffer.
  assign w_push      = w_accept && w_req_legal && (r_state != StIdle);

  // State register
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_pop || w_start_new) w_state_next = StDrive;
      StDrive: w_state_next = StLatch;
      StLatch: w_state_next = w_pop ? StDrive : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Current transfer, skid buffer and registered pulses
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_cur_src   <= '0;
      r_cur_dst   <= '0;
      r_buf_src   <= '0;
      r_buf_dst   <= '0;
      r_buf_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cur_src <= r_buf_src;
        r_cur_dst <= r_buf_dst;
      end else if (w_start_new) begin
        r_cur_src <= i_req_src;
        r_cur_dst <= i_req_dst;
      end
      // Push requires an empty buffer and pop a full one, so they never coincide.
      if (w_push) begin
        r_buf_valid <= 1'b1;
        r_buf_src   <= i_req_src;
        r_buf_dst   <= i_req_dst;
      end else if (w_pop) begin
        r_buf_valid <= 1'b0;
      end
      r_done <= (r_state == StLatch);
      r_err  <= w_accept && !w_req_legal;
    end
  end

  // Output decode from registered state only
  always_comb begin
    o_src_out = '0;
    o_dst_in  = '0;
    for (int i = 0; i < NSRC; i++) begin
      o_src_out[i] = (r_state != StIdle) && (r_cur_src == 5'(i));
    end
    for (int i = 0; i < NDST; i++) begin
      o_dst_in[i] = (r_state == StLatch) && (r_cur_dst == 5'(i));
    end
  end

  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_busy = (r_state != StIdle) || r_buf_valid;

endmodule
